// File: rtl/tile_scheduler.sv
// -----------------------------------------------------------------------------
// tile_scheduler
//
// Frame-level sequencer: walks a framebuffer tile by tile, strobing the raster
// controller (tile_start) and the tile writer (write_start), and computes the
// SDRAM destination address of every tile. Rasterisation of tile N+1 overlaps
// the write-out of tile N through the double-buffered tile RAM, because
// write_start also swaps the buffers.
//
// Optional feature macro: TILE_SCHED_PERF_EN
//   defined   -> frame_cycles reports the length of the last frame in cycles
//   undefined -> frame_cycles is tied to 0
//
// Handshake: frame_start and abort are single-cycle pulses sampled on the
// rising edge of gpu_clk. tile_start / write_start / done are single-cycle
// pulses. write_addr is valid while write_start is high. A new write_start is
// only issued after writer_reading has been seen low; the frame ends only after
// writer_reading=0 and writer_flushed=1.
//
// Ports:
//   gpu_clk, gpu_rst          clock, asynchronous active-high reset
//   frame_start, abort        control pulses
//   base_addr, stride         address of tile (0,0), row pitch in bytes
//   tiles_x, tiles_y          frame size in tiles
//   raster_busy               raster controller status
//   writer_reading            tile writer still reading tile RAM
//   writer_flushed            tile writer FIFO drained
//   tile_start, write_start   strobes to raster controller / tile writer
//   tile_x, tile_y            indices of the tile being rasterised
//   write_addr                destination address of the tile being written
//   busy, done, aborted       frame status
//   frame_cycles              length of the last frame (perf build only)
// -----------------------------------------------------------------------------
module tile_scheduler #(
    parameter int TILE_W_BYTES = 64,
    parameter int TILE_ROWS    = 32
) (
    input  logic        gpu_clk,
    input  logic        gpu_rst,
    input  logic        frame_start,
    input  logic        abort,
    input  logic [31:0] base_addr,
    input  logic [15:0] stride,
    input  logic [7:0]  tiles_x,
    input  logic [7:0]  tiles_y,
    input  logic        raster_busy,
    input  logic        writer_reading,
    input  logic        writer_flushed,
    output logic        tile_start,
    output logic        write_start,
    output logic [7:0]  tile_x,
    output logic [7:0]  tile_y,
    output logic [31:0] write_addr,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [31:0] frame_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_RSTART, S_RARM, S_RWAIT, S_WWAIT, S_WSTART, S_FLUSH, S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_stride;
    logic [7:0]  r_tiles_x;
    logic [7:0]  r_tiles_y;
    logic [7:0]  r_cx;
    logic [7:0]  r_cy;
    logic [31:0] r_row_base;

    logic        r_tile_start;
    logic        r_write_start;
    logic [7:0]  r_tile_x;
    logic [7:0]  r_tile_y;
    logic [31:0] r_write_addr;
    logic        r_busy;
    logic        r_done;
    logic        r_aborted;

    logic        w_accept;
    logic        w_abort_ok;
    logic        w_last_tile;
    logic        w_stop;
    logic        w_row_end;
    logic [31:0] w_row_step;
    logic [31:0] w_tile_addr;

    assign w_accept    = (r_state == S_IDLE) && frame_start;
    assign w_abort_ok  = abort && (r_state inside {S_RSTART, S_RARM, S_RWAIT, S_WWAIT, S_WSTART});
    assign w_last_tile = (r_cx == r_tiles_x - 8'd1) && (r_cy == r_tiles_y - 8'd1);
    // r_aborted doubles as the pending-abort flag: it is cleared on acceptance.
    // An abort arriving in WSTART itself still ends the frame after this tile.
    assign w_stop      = w_last_tile || r_aborted || abort;
    assign w_row_end   = ({1'b0, r_cx} + 9'd1) >= {1'b0, r_tiles_x};
    assign w_row_step  = 32'(r_stride) * 32'(TILE_ROWS);
    assign w_tile_addr = r_row_base + 32'(r_cx) * 32'(TILE_W_BYTES);

    // State register
    always_ff @(posedge gpu_clk or posedge gpu_rst) begin
        if (gpu_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    if (tiles_x == 8'd0 || tiles_y == 8'd0) w_next = S_FIN;
                    else                                    w_next = S_RSTART;
                end
            end
            S_RSTART: w_next = S_RARM;
            S_RARM:   w_next = S_RWAIT;  // raster_busy not yet valid for this tile
            S_RWAIT:  if (!raster_busy)    w_next = S_WWAIT;
            S_WWAIT:  if (!writer_reading) w_next = S_WSTART;
            S_WSTART: w_next = w_stop ? S_FLUSH : S_RSTART;
            S_FLUSH:  if (!writer_reading && writer_flushed) w_next = S_FIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs. tile_start/done follow the current
    // state; write_start follows the next state so that it lands two cycles
    // after raster_busy falls.
    always_ff @(posedge gpu_clk or posedge gpu_rst) begin
        if (gpu_rst) begin
            r_stride      <= '0;
            r_tiles_x     <= '0;
            r_tiles_y     <= '0;
            r_cx          <= '0;
            r_cy          <= '0;
            r_row_base    <= '0;
            r_tile_start  <= 1'b0;
            r_write_start <= 1'b0;
            r_tile_x      <= '0;
            r_tile_y      <= '0;
            r_write_addr  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_tile_start  <= (r_state == S_RSTART);
            r_write_start <= (w_next == S_WSTART);
            r_done        <= (r_state == S_FIN);
            r_busy        <= (w_next != S_IDLE);

            if (r_state == S_RSTART) begin
                r_tile_x <= r_cx;
                r_tile_y <= r_cy;
            end

            if (w_next == S_WSTART) begin
                r_write_addr <= w_tile_addr;
            end

            if (w_accept) begin
                r_stride   <= stride;
                r_tiles_x  <= tiles_x;
                r_tiles_y  <= tiles_y;
                r_cx       <= '0;
                r_cy       <= '0;
                r_row_base <= base_addr;
                r_aborted  <= 1'b0;
            end else begin
                if (w_abort_ok) begin
                    r_aborted <= 1'b1;
                end
                if (r_state == S_WSTART) begin
                    if (w_row_end) begin
                        r_cx       <= '0;
                        r_cy       <= r_cy + 8'd1;
                        r_row_base <= r_row_base + w_row_step;
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                end
            end
        end
    end

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_frame_cycles;

    // Counts the acceptance cycle through the FIN cycle inclusive.
    always_ff @(posedge gpu_clk or posedge gpu_rst) begin
        if (gpu_rst) begin
            r_cycle_cnt    <= '0;
            r_frame_cycles <= '0;
        end else begin
            if (w_accept) begin
                r_cycle_cnt <= 32'd1;
            end else if (r_state != S_IDLE) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (r_state == S_FIN) begin
                r_frame_cycles <= r_cycle_cnt + 32'd1;
            end
        end
    end

    assign frame_cycles = r_frame_cycles;
`else
    assign frame_cycles = '0;
`endif

    assign tile_start  = r_tile_start;
    assign write_start = r_write_start;
    assign tile_x      = r_tile_x;
    assign tile_y      = r_tile_y;
    assign write_addr  = r_write_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;

endmodule

// File: tb/tb_tile_scheduler.sv
module tb_tile_scheduler;

  logic        gpu_clk = 1'b0;
  logic        gpu_rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] stride = '0;
  logic [7:0]  tiles_x = '0;
  logic [7:0]  tiles_y = '0;
  logic        raster_busy;
  logic        writer_reading;
  logic        writer_flushed;
  logic        tile_start;
  logic        write_start;
  logic [7:0]  tile_x;
  logic [7:0]  tile_y;
  logic [31:0] write_addr;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] frame_cycles;

  // clock / reset
  always #5 gpu_clk = ~gpu_clk;

  tile_scheduler dut (
    .gpu_clk        (gpu_clk),
    .gpu_rst        (gpu_rst),
    .frame_start    (frame_start),
    .abort          (abort),
    .base_addr      (base_addr),
    .stride         (stride),
    .tiles_x        (tiles_x),
    .tiles_y        (tiles_y),
    .raster_busy    (raster_busy),
    .writer_reading (writer_reading),
    .writer_flushed (writer_flushed),
    .tile_start     (tile_start),
    .write_start    (write_start),
    .tile_x         (tile_x),
    .tile_y         (tile_y),
    .write_addr     (write_addr),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .frame_cycles   (frame_cycles)
  );

  // downstream models: raster busy r_len cycles after tile_start; writer reads
  // w_len cycles after write_start, then needs f_len cycles to flush
  int r_len = 10;
  int w_len = 3;
  int f_len = 2;
  int rcnt, wcnt, fcnt;

  always @(posedge gpu_clk or posedge gpu_rst) begin
    if (gpu_rst) begin
      rcnt <= 0;
      wcnt <= 0;
      fcnt <= 0;
    end else begin
      if (tile_start) rcnt <= r_len;
      else if (rcnt > 0) rcnt <= rcnt - 1;
      if (write_start) begin
        wcnt <= w_len;
        fcnt <= f_len;
      end else if (wcnt > 0) begin
        wcnt <= wcnt - 1;
      end else if (fcnt > 0) begin
        fcnt <= fcnt - 1;
      end
    end
  end

  assign raster_busy    = (rcnt != 0);
  assign writer_reading = (wcnt != 0);
  assign writer_flushed = (wcnt == 0) && (fcnt == 0);

  // scoreboard
  logic [31:0] exp_q[$];
  logic [15:0] exp_tile_q[$];
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  int ncyc = 0;
  int ws_cnt, ts_cnt, done_cnt;
  int t_ws, t_rfall, t_done, t_acc;
  bit first_tile, chk_lat, chk_overlap, prev_rb;

  always @(negedge gpu_clk) begin
    ncyc++;
    if (!gpu_rst) begin
      if (prev_rb && !raster_busy) t_rfall = ncyc;
      prev_rb = raster_busy;
      if (write_start) begin
        ws_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write_start: addr 0x%0h, expected none", write_addr);
        end else begin
          chk("write_addr", write_addr, exp_q.pop_front());
        end
        chk("ws_overlap_busy", {29'd0, writer_reading, raster_busy, tile_start}, 32'd0);
        if (chk_lat) chk("raster_fall_to_ws", ncyc - t_rfall, 2);
        t_ws = ncyc;
      end
      if (tile_start) begin
        ts_cnt++;
        if (exp_tile_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_tile_start: tile (%0d,%0d), expected none", tile_x, tile_y);
        end else begin
          chk("tile_xy", {16'd0, tile_y, tile_x}, {16'd0, exp_tile_q.pop_front()});
        end
        if (!first_tile && chk_lat) chk("ws_to_ts", ncyc - t_ws, 2);
        if (!first_tile && chk_overlap) chk("raster_overlaps_drain", writer_reading, 1);
        first_tile = 1'b0;
      end
      if (done) begin
        done_cnt++;
        t_done = ncyc;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge gpu_clk);
      #1;
    end
  endtask

  task automatic new_frame();
    ws_cnt = 0;
    ts_cnt = 0;
    done_cnt = 0;
    first_tile = 1'b1;
  endtask

  task automatic push_tile(input logic [7:0] x, input logic [7:0] y, input logic [31:0] a, input bit with_addr);
    exp_tile_q.push_back({y, x});
    if (with_addr) exp_q.push_back(a);
  endtask

  task automatic start_frame(input logic [31:0] b, input logic [15:0] s,
                             input logic [7:0] tx, input logic [7:0] ty, input logic ab);
    base_addr = b;
    stride = s;
    tiles_x = tx;
    tiles_y = ty;
    frame_start = 1'b1;
    abort = ab;
    t_acc = ncyc;
    tick();
    frame_start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int start;
    start = done_cnt;
    for (int i = 0; i < max && done_cnt == start; i++) tick();
    chk(name, {31'd0, done_cnt > start}, 1);
  endtask

  task automatic wait_ts(input int n, input int max);
    for (int i = 0; i < max && ts_cnt < n; i++) tick();
    chk("wait_tile_start", {31'd0, ts_cnt >= n}, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tile_start"}, tile_start, 0);
    chk({tag, "_write_start"}, write_start, 0);
    chk({tag, "_tile_x"}, tile_x, 0);
    chk({tag, "_tile_y"}, tile_y, 0);
    chk({tag, "_write_addr"}, write_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_frame_cycles"}, frame_cycles, 0);
  endtask

  task automatic check_frame_end(input string tag, input int n_ws, input int n_ts);
    chk({tag, "_ws_count"}, ws_cnt, n_ws);
    chk({tag, "_ts_count"}, ts_cnt, n_ts);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_addr_q_empty"}, exp_q.size(), 0);
    chk({tag, "_tile_q_empty"}, exp_tile_q.size(), 0);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  // watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    tick(3);
    check_reset_outputs("reset");
    gpu_rst = 1'b0;
    tick(2);

    // reset mid-RWAIT
    new_frame();
    push_tile(8'd0, 8'd0, 32'd0, 1'b0);
    start_frame(32'h1000, 16'd1280, 8'd2, 8'd2, 1'b0);
    wait_ts(1, 50);
    tick(3);
    gpu_rst = 1'b1;
    tick();
    check_reset_outputs("midreset");
    gpu_rst = 1'b0;
    tick(2);
    chk("midreset_tile_q_empty", exp_tile_q.size(), 0);

    // 2x2 frame, latency checks enabled
    new_frame();
    chk_lat = 1'b1;
    push_tile(8'd0, 8'd0, 32'h1000, 1'b1);
    push_tile(8'd1, 8'd0, 32'h1040, 1'b1);
    push_tile(8'd0, 8'd1, 32'hB000, 1'b1);
    push_tile(8'd1, 8'd1, 32'hB040, 1'b1);
    start_frame(32'h1000, 16'd1280, 8'd2, 8'd2, 1'b0);
    chk("busy_after_accept", busy, 1);
    chk("ts_not_yet", tile_start, 0);
    tick();
    chk("ts_two_cycles", tile_start, 1);
    wait_done("done_2x2", 500);
    chk("busy_low_with_done", busy, 0);
    tick(3);
    check_frame_end("f2x2", 4, 4);
    chk("f2x2_aborted", aborted, 0);
    chk_lat = 1'b0;

    // 3x1 frame, slow writer, ignored frame_start mid-frame
    new_frame();
    w_len = 50;
    chk_overlap = 1'b1;
    push_tile(8'd0, 8'd0, 32'h2000, 1'b1);
    push_tile(8'd1, 8'd0, 32'h2040, 1'b1);
    push_tile(8'd2, 8'd0, 32'h2080, 1'b1);
    start_frame(32'h2000, 16'd64, 8'd3, 8'd1, 1'b0);
    tick(30);
    base_addr = 32'hDEAD_0000;
    tiles_x = 8'd5;
    tiles_y = 8'd5;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("busy_during_ignored_start", busy, 1);
    wait_done("done_3x1", 3000);
    tick(3);
    check_frame_end("f3x1", 3, 3);
    w_len = 3;
    chk_overlap = 1'b0;

    // zero-size frame
    new_frame();
    start_frame(32'h3000, 16'd100, 8'd0, 8'd4, 1'b0);
    chk("zero_done_early", done, 0);
    tick();
    chk("zero_done_two_cycles", done, 1);
    chk("zero_aborted", aborted, 0);
`ifdef TILE_SCHED_PERF_EN
    chk("zero_frame_cycles", frame_cycles, 2);
`endif
    tick(3);
    check_frame_end("zero", 0, 0);

    // abort in IDLE has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("idle_abort_ignored", aborted, 0);

    // abort during RWAIT of tile 1 of a 4x1 frame
    new_frame();
    f_len = 15;
    push_tile(8'd0, 8'd0, 32'h0000, 1'b1);
    push_tile(8'd1, 8'd0, 32'h0040, 1'b1);
    start_frame(32'h0, 16'd256, 8'd4, 8'd1, 1'b0);
    wait_ts(2, 200);
    tick(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_sets_aborted", aborted, 1);
    wait_done("done_abort", 500);
    chk("flush_waited", {31'd0, (t_done - t_ws) >= 18}, 1);
    tick(3);
    check_frame_end("abort", 2, 2);
    chk("abort_sticky", aborted, 1);
    f_len = 2;

    // 1x1 frame with simultaneous abort at start; perf counter
    new_frame();
    f_len = 20;
    push_tile(8'd0, 8'd0, 32'h4000_0000, 1'b1);
    start_frame(32'h4000_0000, 16'd512, 8'd1, 8'd1, 1'b1);
    wait_done("done_1x1", 500);
`ifdef TILE_SCHED_PERF_EN
    chk("frame_cycles", frame_cycles, t_done - t_acc);
    tick(3);
    chk("frame_cycles_hold", frame_cycles, t_done - t_acc);
`else
    chk("frame_cycles_zero", frame_cycles, 0);
    tick(3);
`endif
    check_frame_end("f1x1", 1, 1);
    chk("start_abort_ignored", aborted, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
